// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//
// Purpose:
//   This is the output stage after the lock state machine. It takes four 5-bit
//   symbol codes, decodes each code to seven-segment patterns, and scans a
//   four-digit common-anode display. It also blinks digits at BLINK_HZ, so the
//   upstream logic only needs to supply a static per-digit blink mask.
//
//   The symbol word and the blink mask are latched once per frame, at the
//   point where the scan index wraps from 0 back to 3. A frame is therefore
//   always drawn from one consistent snapshot. A change made mid-frame shows
//   up in the following frame.
//
// Ports:
//   clk         in   1   system clock
//   rst         in   1   synchronous active-high reset
//   sym         in  20   symbol codes, [19:15]=digit3 (left) .. [4:0]=digit0
//   blink_mask  in   4   bit i set makes digit i blink
//   seg         out  7   segments {g,f,e,d,c,b,a}, active-low
//   an          out  4   anode enables, active-low, an[i] drives digit i
//   dp          out  1   decimal point, active-low
//   blink_on    out  1   current blink phase (1 = visible)
//
// Parameters:
//   CLK_HZ    input clock frequency
//   SCAN_HZ   full-frame refresh rate; slot length = CLK_HZ/(4*SCAN_HZ)
//   BLINK_HZ  blink rate; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
//
// Optional build macro:
//   SSD_DP_BLINK_EN - when defined, the decimal point of a blinking digit is
//   lit while that digit is blanked. This acts as a cursor marker. When it is
//   undefined, dp is tied high.
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
    parameter int CLK_HZ   = 100000000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] sym,
    input  logic [3:0]  blink_mask,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        blink_on
);

    localparam int SLOT   = CLK_HZ / (4 * SCAN_HZ);
    localparam int HALF   = CLK_HZ / (2 * BLINK_HZ);
    localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam logic [19:0] HOLD_BLANK = 20'hFFFFF;   // 0x1F on all four digits

    // Timing state
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [SLOT_W-1:0] w_slot_cnt_next;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_next;
    logic [HALF_W-1:0] r_blink_cnt;
    logic [HALF_W-1:0] w_blink_cnt_next;
    logic              r_blink_on;
    logic              w_blink_on_next;

    // Frame holding registers
    logic [19:0]       r_sym_hold;
    logic [19:0]       w_sym_hold_next;
    logic [3:0]        r_mask_hold;
    logic [3:0]        w_mask_hold_next;

    // Registered display outputs
    logic [6:0]        r_seg;
    logic [6:0]        w_seg_next;
    logic [3:0]        r_an;
    logic [3:0]        w_an_next;

    logic              w_slot_wrap;
    logic              w_frame_wrap;
    logic              w_blink_wrap;
    logic              w_blank;
    logic [4:0]        w_digit_code [4];
    logic [4:0]        w_code;
    logic [6:0]        w_seg_dec;

    // Split the held word into its four digit codes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign w_digit_code[gi] = r_sym_hold[gi*5 +: 5];
        end
    endgenerate

    assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
    // The frame ends when the last slot of digit 0 wraps. The index is about to return to 3.
    assign w_frame_wrap = w_slot_wrap && (r_idx == 2'd0);
    assign w_blink_wrap = (r_blink_cnt == HALF_LAST);

    // Counter and latch next-state
    always_comb begin
        w_slot_cnt_next  = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
        // The 2-bit decrement wraps 0 -> 3 naturally.
        w_idx_next       = w_slot_wrap ? r_idx - 2'd1 : r_idx;
        w_blink_cnt_next = w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
        w_blink_on_next  = w_blink_wrap ? ~r_blink_on : r_blink_on;
        w_sym_hold_next  = r_sym_hold;
        w_mask_hold_next = r_mask_hold;
        if (w_frame_wrap) begin
            w_sym_hold_next  = sym;
            w_mask_hold_next = blink_mask;
        end
    end

    // Symbol decode for the digit under the current index
    assign w_code = w_digit_code[r_idx];

    always_comb begin
        w_seg_dec = SEG_BLANK;
        case (w_code)
            5'h00: w_seg_dec = 7'h40;
            5'h01: w_seg_dec = 7'h79;
            5'h02: w_seg_dec = 7'h24;
            5'h03: w_seg_dec = 7'h30;
            5'h04: w_seg_dec = 7'h19;
            5'h05: w_seg_dec = 7'h12;
            5'h06: w_seg_dec = 7'h02;
            5'h07: w_seg_dec = 7'h78;
            5'h08: w_seg_dec = 7'h00;
            5'h09: w_seg_dec = 7'h10;
            5'h0A: w_seg_dec = 7'h08;
            5'h0B: w_seg_dec = 7'h03;
            5'h0C: w_seg_dec = 7'h46;
            5'h0D: w_seg_dec = 7'h21;
            5'h0E: w_seg_dec = 7'h06;
            5'h0F: w_seg_dec = 7'h0E;
            5'h10: w_seg_dec = 7'h46;   // 'C'
            5'h11: w_seg_dec = 7'h47;   // 'L'
            5'h12: w_seg_dec = 7'h40;   // 'O'
            5'h13: w_seg_dec = 7'h0C;   // 'P'
            5'h14: w_seg_dec = 7'h2B;   // 'n'
            5'h15: w_seg_dec = 7'h3F;   // '-'
            5'h16: w_seg_dec = 7'h2F;   // 'r'
            5'h17: w_seg_dec = 7'h41;   // 'U'
            default: w_seg_dec = SEG_BLANK;
        endcase
    end

    // A blinking digit in its off phase is blanked. Its anode stays asserted,
    // so the scan duty cycle does not change.
    assign w_blank = r_mask_hold[r_idx] & ~r_blink_on;

    always_comb begin
        w_an_next  = ~(4'b0001 << r_idx);
        w_seg_next = w_blank ? SEG_BLANK : w_seg_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt  <= '0;
            r_idx       <= 2'd3;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_sym_hold  <= HOLD_BLANK;
            r_mask_hold <= 4'h0;
            r_seg       <= SEG_BLANK;
            r_an        <= 4'hF;
        end else begin
            r_slot_cnt  <= w_slot_cnt_next;
            r_idx       <= w_idx_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_blink_on  <= w_blink_on_next;
            r_sym_hold  <= w_sym_hold_next;
            r_mask_hold <= w_mask_hold_next;
            r_seg       <= w_seg_next;
            r_an        <= w_an_next;
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign blink_on = r_blink_on;

`ifdef SSD_DP_BLINK_EN
    // Cursor marker: dp is lit exactly when the scanned digit is blanked by blinking.
    logic r_dp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp <= 1'b1;
        end else begin
            r_dp <= ~w_blank;
        end
    end

    assign dp = r_dp;
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
//
// This bench runs the scan driver with CLK_HZ=80, SCAN_HZ=5 and BLINK_HZ=1,
// which gives a 4-cycle slot and a 40-cycle blink half-period.
//
// On every clock, a reference model predicts all outputs. The model works
// from the cycle count since reset release: the slot number, the frame
// number and the blink phase all come from integer division. It also keeps
// the snapshot taken at each frame boundary.
//
// The bench also runs a table of static frames and several hand-written
// sequences. These cover blinking, a mid-frame update and a mid-frame reset.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

    localparam int SLOT  = 4;
    localparam int HALF  = 40;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        rst;
    logic [19:0] sym;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        blink_on;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: edges since reset release, and the snapshot being displayed.
    int          e = 0;
    logic [19:0] m_hold = 20'hFFFFF;
    logic [3:0]  m_mask = 4'h0;

    ssd_scan_driver #(
        .CLK_HZ   (80),
        .SCAN_HZ  (5),
        .BLINK_HZ (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sym        (sym),
        .blink_mask (blink_mask),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .blink_on   (blink_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [4:0] c);
        case (c)
            5'h00: return 7'h40;  5'h01: return 7'h79;  5'h02: return 7'h24;
            5'h03: return 7'h30;  5'h04: return 7'h19;  5'h05: return 7'h12;
            5'h06: return 7'h02;  5'h07: return 7'h78;  5'h08: return 7'h00;
            5'h09: return 7'h10;  5'h0A: return 7'h08;  5'h0B: return 7'h03;
            5'h0C: return 7'h46;  5'h0D: return 7'h21;  5'h0E: return 7'h06;
            5'h0F: return 7'h0E;  5'h10: return 7'h46;  5'h11: return 7'h47;
            5'h12: return 7'h40;  5'h13: return 7'h0C;  5'h14: return 7'h2B;
            5'h15: return 7'h3F;  5'h16: return 7'h2F;  5'h17: return 7'h41;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    // Advance one clock. Predict the outputs from the model, then compare them.
    task automatic step();
        logic [19:0] s_sym;
        logic [3:0]  s_mask;
        logic        s_rst;
        int          t;
        int          idx;
        logic        phase_prev;
        logic        blank;
        logic [6:0]  xs;
        logic [3:0]  xa;
        logic        xd;
        logic        xb;
        @(posedge clk);
        s_sym  = sym;
        s_mask = blink_mask;
        s_rst  = rst;
        #1;
        if (s_rst) begin
            e      = 0;
            m_hold = 20'hFFFFF;
            m_mask = 4'h0;
            xs = 7'h7F; xa = 4'hF; xd = 1'b1; xb = 1'b1;
        end else begin
            e++;
            t          = e - 1;                       // state that produced these outputs
            idx        = 3 - ((t / SLOT) % 4);
            phase_prev = ((t / HALF) % 2) == 0;
            xa         = 4'hF;
            xa[idx]    = 1'b0;
            blank      = m_mask[idx] && !phase_prev;
            xs         = blank ? 7'h7F : ref_seg(m_hold[idx*5 +: 5]);
`ifdef SSD_DP_BLINK_EN
            xd = !blank;
`else
            xd = 1'b1;
`endif
            xb = ((e / HALF) % 2) == 0;
            if (e % FRAME == 0) begin
                m_hold = s_sym;
                m_mask = s_mask;
            end
        end
        chk("model_seg", 32'(seg), 32'(xs));
        chk("model_an", 32'(an), 32'(xa));
        chk("model_dp", 32'(dp), 32'(xd));
        chk("model_blink_on", 32'(blink_on), 32'(xb));
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 5000 && e < target; k++) step();
        if (e != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_to: reached edge %0d, required %0d", e, target);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) step();
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [19:0] sym;
        logic [6:0]  s3;
        logic [6:0]  s2;
        logic [6:0]  s1;
        logic [6:0]  s0;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] c3, c2, c1, c0,
                                input logic [6:0] s3, s2, s1, s0);
        vec_t v;
        v.sym = {c3, c2, c1, c0};
        v.s3 = s3; v.s2 = s2; v.s1 = s1; v.s0 = s0;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        logic [6:0] seg_exp;
        logic [3:0] an_exp;

        rst        = 1'b1;
        sym        = 20'h0;
        blink_mask = 4'h0;

        vecs[0] = mk(5'h10, 5'h11, 5'h05, 5'h0D, 7'h46, 7'h47, 7'h12, 7'h21);
        vecs[1] = mk(5'h18, 5'h1E, 5'h1F, 5'h17, 7'h7F, 7'h7F, 7'h7F, 7'h41);
        vecs[2] = mk(5'h00, 5'h01, 5'h02, 5'h03, 7'h40, 7'h79, 7'h24, 7'h30);
        vecs[3] = mk(5'h04, 5'h05, 5'h06, 5'h07, 7'h19, 7'h12, 7'h02, 7'h78);
        vecs[4] = mk(5'h08, 5'h09, 5'h0A, 5'h0B, 7'h00, 7'h10, 7'h08, 7'h03);
        vecs[5] = mk(5'h0C, 5'h0E, 5'h0F, 5'h12, 7'h46, 7'h06, 7'h0E, 7'h40);
        vecs[6] = mk(5'h0D, 5'h13, 5'h14, 5'h16, 7'h21, 7'h0C, 7'h2B, 7'h2F);
        vecs[7] = mk(5'h15, 5'h10, 5'h11, 5'h12, 7'h3F, 7'h46, 7'h47, 7'h40);

        // Reset, then the first slot shows the blank hold on digit 3.
        do_reset(3);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_blink_on", 32'(blink_on), 32'h1);
        step();
        chk("first_slot_an", 32'(an), 32'h7);
        chk("first_slot_seg", 32'(seg), 32'h7F);

        // Static frames: check each slot in the frame after the first latch.
        for (int v = 0; v < 8; v++) begin
            do_reset(3);
            sym        = vecs[v].sym;
            blink_mask = 4'h0;
            run_to(FRAME);
            for (int k = 0; k < 4; k++) begin
                run_to(FRAME + SLOT * k + 2);
                an_exp = ~(4'b0001 << (3 - k));
                case (k)
                    0: seg_exp = vecs[v].s3;
                    1: seg_exp = vecs[v].s2;
                    2: seg_exp = vecs[v].s1;
                    default: seg_exp = vecs[v].s0;
                endcase
                chk($sformatf("table%0d_an%0d", v, k), 32'(an), 32'(an_exp));
                chk($sformatf("table%0d_seg%0d", v, k), 32'(seg), 32'(seg_exp));
            end
        end

        // Blink digit 3: visible, then blanked with the anode still asserted, then visible again.
        do_reset(3);
        sym        = {5'h00, 5'h1F, 5'h1F, 5'h1F};
        blink_mask = 4'b1000;
        run_to(18);
        chk("blink_on_an", 32'(an), 32'h7);
        chk("blink_on_seg", 32'(seg), 32'h40);
        run_to(40);
        chk("blink_toggle_off", 32'(blink_on), 32'h0);
        run_to(50);
        chk("blink_off_an", 32'(an), 32'h7);
        chk("blink_off_seg", 32'(seg), 32'h7F);
        run_to(80);
        chk("blink_toggle_on", 32'(blink_on), 32'h1);
        run_to(82);
        chk("blink_back_seg", 32'(seg), 32'h40);
        run_to(120);
        chk("blink_period", 32'(blink_on), 32'h0);

        // Mid-frame update while digit 1 is scanned.
        do_reset(3);
        sym        = {5'h10, 5'h11, 5'h05, 5'h0D};
        blink_mask = 4'h0;
        run_to(26);
        sym = {5'h15, 5'h03, 5'h1F, 5'h1F};
        run_to(28);
        chk("mid_old_an1", 32'(an), 32'hD);
        chk("mid_old_seg1", 32'(seg), 32'h12);
        run_to(30);
        chk("mid_old_an0", 32'(an), 32'hE);
        chk("mid_old_seg0", 32'(seg), 32'h21);
        run_to(34);
        chk("mid_new_seg3", 32'(seg), 32'h3F);
        run_to(38);
        chk("mid_new_seg2", 32'(seg), 32'h30);
        run_to(42);
        chk("mid_new_seg1", 32'(seg), 32'h7F);
        run_to(46);
        chk("mid_new_an0", 32'(an), 32'hE);
        chk("mid_new_seg0", 32'(seg), 32'h7F);

        // Digit 0 blinking in its off phase, then a reset in the middle of the frame.
        do_reset(3);
        sym        = {5'h01, 5'h02, 5'h03, 5'h04};
        blink_mask = 4'b0001;
        run_to(58);
        chk("dp_other_slot", 32'(dp), 32'h1);
        run_to(62);
        chk("dp_slot_an", 32'(an), 32'hE);
        chk("dp_slot_seg", 32'(seg), 32'h7F);
`ifdef SSD_DP_BLINK_EN
        chk("dp_slot_dp", 32'(dp), 32'h0);
`else
        chk("dp_slot_dp", 32'(dp), 32'h1);
`endif
        run_to(63);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_dp", 32'(dp), 32'h1);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_blink_on", 32'(blink_on), 32'h1);
        run_to(2);
        chk("midrst_blank_seg", 32'(seg), 32'h7F);

        // Randomized inputs with occasional resets, checked by the model every cycle.
        do_reset(2);
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 7) == 0) sym = 20'($urandom);
            if ($urandom_range(0, 9) == 0) blink_mask = 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
